// File: rtl/vx_warp_pc_ctrl.sv
// vx_warp_pc_ctrl: per-warp PC table and round-robin fetch arbiter.
// Warps are activated by spawn, blocked by decode stalls until their branch
// resolves, and presented to fetch through a registered valid/ready port.
// Optional feature macro: BRANCH_PERF_EN adds saturating taken/not-taken
// branch counters on extra ports perf_taken_o / perf_not_taken_o.
module vx_warp_pc_ctrl #(
  parameter int NUM_WARPS = 4,
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] STARTUP_ADDR = 32'h80000000,
  localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wspawn_valid,
  input  logic [NUM_WARPS-1:0] wspawn_mask,
  input  logic [XLEN-1:0]      wspawn_pc,
  input  logic                 stall_valid,
  input  logic [NW_BITS-1:0]   stall_wid,
  input  logic                 branch_valid,
  input  logic [NW_BITS-1:0]   branch_wid,
  input  logic                 branch_taken,
  input  logic [XLEN-1:0]      branch_dest,
  output logic                 sched_valid,
  output logic [NW_BITS-1:0]   sched_wid,
  output logic [XLEN-1:0]      sched_pc,
`ifdef BRANCH_PERF_EN
  output logic [31:0]          perf_taken_o,
  output logic [31:0]          perf_not_taken_o,
`endif
  input  logic                 sched_ready
);

  // Output request register and round-robin pointer
  logic                 sched_valid_reg;
  logic [NW_BITS-1:0]   sched_wid_reg;
  logic [XLEN-1:0]      sched_pc_reg;
  logic [NW_BITS-1:0]   rr_ptr_reg;

  // Flattened views of the per-warp state
  logic [NUM_WARPS-1:0] eligible;
  logic [XLEN-1:0]      pc_vec [NUM_WARPS];

  // Arbiter result
  logic                 sel_found;
  logic [NW_BITS-1:0]   sel_wid;
  logic [NW_BITS-1:0]   cand;

  // A request is held while it is valid and fetch is not accepting it.
  logic held;
  logic load_en;
  logic kill;

  assign held    = sched_valid_reg & ~sched_ready;
  assign load_en = ~held;
  // A branch resolving for the held warp drops that stale request.
  assign kill    = branch_valid & held & (branch_wid == sched_wid_reg);

  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
    logic            active_reg;
    logic            stalled_reg;
    logic [XLEN-1:0] pc_reg;
    logic            spawn_hit;
    logic            branch_hit;
    logic            stall_hit;
    logic            grant_hit;

    assign spawn_hit  = wspawn_valid & wspawn_mask[gi];
    assign branch_hit = branch_valid & (branch_wid == NW_BITS'(gi));
    assign stall_hit  = stall_valid & (stall_wid == NW_BITS'(gi)) & active_reg;
    assign grant_hit  = load_en & sel_found & (sel_wid == NW_BITS'(gi));

    // Warps being spawned or branch-updated this cycle sit out arbitration so
    // the PC write they receive is never overwritten by a +4 advance.
    assign eligible[gi] = active_reg & ~stalled_reg
                        & ~(held & (sched_wid_reg == NW_BITS'(gi)))
                        & ~branch_hit & ~spawn_hit;
    assign pc_vec[gi] = pc_reg;

    // Per-warp state update: spawn > branch > stall/advance
    always_ff @(posedge clk) begin
      if (reset) begin
        active_reg  <= (gi == 0);
        stalled_reg <= 1'b0;
        pc_reg      <= (gi == 0) ? STARTUP_ADDR : '0;
      end else if (spawn_hit) begin
        active_reg  <= 1'b1;
        stalled_reg <= 1'b0;
        pc_reg      <= wspawn_pc;
      end else if (branch_hit) begin
        // A stall landing in the same cycle keeps the warp blocked.
        stalled_reg <= stall_hit;
        if (branch_taken) begin
          pc_reg <= branch_dest;
        end else if (kill) begin
          // The dropped request must be refetched on fall-through.
          pc_reg <= sched_pc_reg;
        end
      end else begin
        if (stall_hit) begin
          stalled_reg <= 1'b1;
        end
        if (grant_hit) begin
          pc_reg <= pc_reg + XLEN'(4);
        end
      end
    end
  end

  // Round-robin search: first eligible warp after rr_ptr, wrapping around.
  // Scanning from the far end lets the nearest candidate win last.
  always_comb begin
    sel_found = 1'b0;
    sel_wid   = '0;
    cand      = '0;
    for (int i = NUM_WARPS; i >= 1; i--) begin
      cand = rr_ptr_reg + NW_BITS'(i);
      if (eligible[cand]) begin
        sel_found = 1'b1;
        sel_wid   = cand;
      end
    end
  end

  // Fetch request register: load when empty or fired, drop on branch kill
  always_ff @(posedge clk) begin
    if (reset) begin
      sched_valid_reg <= 1'b0;
      sched_wid_reg   <= '0;
      sched_pc_reg    <= '0;
      rr_ptr_reg      <= '0;
    end else if (kill) begin
      sched_valid_reg <= 1'b0;
    end else if (load_en) begin
      sched_valid_reg <= sel_found;
      if (sel_found) begin
        sched_wid_reg <= sel_wid;
        sched_pc_reg  <= pc_vec[sel_wid];
        rr_ptr_reg    <= sel_wid;
      end
    end
  end

  assign sched_valid = sched_valid_reg;
  assign sched_wid   = sched_wid_reg;
  assign sched_pc    = sched_pc_reg;

`ifdef BRANCH_PERF_EN
  logic [31:0] perf_taken_reg;
  logic [31:0] perf_not_taken_reg;

  // Saturating counters of resolved branch outcomes
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_taken_reg     <= '0;
      perf_not_taken_reg <= '0;
    end else if (branch_valid) begin
      if (branch_taken) begin
        if (perf_taken_reg != '1) begin
          perf_taken_reg <= perf_taken_reg + 32'd1;
        end
      end else if (perf_not_taken_reg != '1) begin
        perf_not_taken_reg <= perf_not_taken_reg + 32'd1;
      end
    end
  end

  assign perf_taken_o     = perf_taken_reg;
  assign perf_not_taken_o = perf_not_taken_reg;
`endif

endmodule

// File: tb/tb_vx_warp_pc_ctrl.sv
// tb_vx_warp_pc_ctrl: directed scenarios plus randomized traffic checked
// against a per-cycle behavioural model of the warp PC controller.
module tb_vx_warp_pc_ctrl;
  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wspawn_valid;
  logic [3:0]  wspawn_mask;
  logic [31:0] wspawn_pc;
  logic        stall_valid;
  logic [1:0]  stall_wid;
  logic        branch_valid;
  logic [1:0]  branch_wid;
  logic        branch_taken;
  logic [31:0] branch_dest;
  logic        sched_valid;
  logic [1:0]  sched_wid;
  logic [31:0] sched_pc;
  logic        sched_ready;
`ifdef BRANCH_PERF_EN
  logic [31:0] perf_taken_o;
  logic [31:0] perf_not_taken_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_warp_pc_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .wspawn_valid (wspawn_valid),
    .wspawn_mask  (wspawn_mask),
    .wspawn_pc    (wspawn_pc),
    .stall_valid  (stall_valid),
    .stall_wid    (stall_wid),
    .branch_valid (branch_valid),
    .branch_wid   (branch_wid),
    .branch_taken (branch_taken),
    .branch_dest  (branch_dest),
    .sched_valid  (sched_valid),
    .sched_wid    (sched_wid),
    .sched_pc     (sched_pc),
`ifdef BRANCH_PERF_EN
    .perf_taken_o     (perf_taken_o),
    .perf_not_taken_o (perf_not_taken_o),
`endif
    .sched_ready  (sched_ready)
  );

  // Reference model state
  bit          m_active [NW];
  bit          m_stalled[NW];
  logic [31:0] m_pc     [NW];
  int          m_rr;
  bit          m_valid;
  int          m_wid;
  logic [31:0] m_out_pc;
  logic [31:0] m_taken;
  logic [31:0] m_not_taken;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int w = 0; w < NW; w++) begin
      m_active[w]  = (w == 0);
      m_stalled[w] = 1'b0;
      m_pc[w]      = (w == 0) ? 32'h8000_0000 : 32'h0;
    end
    m_rr        = 0;
    m_valid     = 1'b0;
    m_wid       = 0;
    m_out_pc    = 32'h0;
    m_taken     = 32'h0;
    m_not_taken = 32'h0;
  endfunction

  // One clock of the controller, from the rules: pick a warp, then apply
  // PC/stall changes in increasing priority (advance, stall, branch, spawn).
  function automatic void model_next();
    bit          held_now;
    bit          kill;
    int          pick;
    bit          nst[NW];
    logic [31:0] npc[NW];
    held_now = m_valid && !sched_ready;
    kill     = branch_valid && held_now && (int'(branch_wid) == m_wid);
    pick     = -1;
    if (!held_now) begin
      for (int k = 1; k <= NW; k++) begin
        int w = (m_rr + k) % NW;
        if (pick < 0 && m_active[w] && !m_stalled[w]
            && !(branch_valid && int'(branch_wid) == w)
            && !(wspawn_valid && wspawn_mask[w]))
          pick = w;
      end
    end
    npc = m_pc;
    nst = m_stalled;
    if (pick >= 0) npc[pick] = m_pc[pick] + 32'd4;
    if (stall_valid && m_active[stall_wid]) nst[stall_wid] = 1'b1;
    if (branch_valid) begin
      if (!(stall_valid && stall_wid == branch_wid)) nst[branch_wid] = 1'b0;
      if (branch_taken) npc[branch_wid] = branch_dest;
      else if (kill) npc[branch_wid] = m_out_pc;
      if (branch_taken) begin
        if (m_taken != 32'hFFFF_FFFF) m_taken = m_taken + 1;
      end else if (m_not_taken != 32'hFFFF_FFFF) begin
        m_not_taken = m_not_taken + 1;
      end
    end
    if (kill) begin
      m_valid = 1'b0;
    end else if (!held_now) begin
      if (pick >= 0) begin
        m_valid  = 1'b1;
        m_wid    = pick;
        m_out_pc = m_pc[pick];
        m_rr     = pick;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int w = 0; w < NW; w++) begin
      if (wspawn_valid && wspawn_mask[w]) begin
        m_active[w] = 1'b1;
        nst[w]      = 1'b0;
        npc[w]      = wspawn_pc;
      end
    end
    m_pc      = npc;
    m_stalled = nst;
  endfunction

  // Advance one clock and compare the DUT against the model.
  task automatic step();
    if (reset) model_reset();
    else model_next();
    @(posedge clk);
    #1;
    chk("sched_valid", 32'(sched_valid), 32'(m_valid));
    if (m_valid) begin
      chk("sched_wid", 32'(sched_wid), 32'(m_wid));
      chk("sched_pc", sched_pc, m_out_pc);
    end
`ifdef BRANCH_PERF_EN
    chk("perf_taken", perf_taken_o, m_taken);
    chk("perf_not_taken", perf_not_taken_o, m_not_taken);
`endif
  endtask

  task automatic clear_inputs();
    wspawn_valid = 1'b0;
    wspawn_mask  = 4'h0;
    wspawn_pc    = 32'h0;
    stall_valid  = 1'b0;
    stall_wid    = 2'd0;
    branch_valid = 1'b0;
    branch_wid   = 2'd0;
    branch_taken = 1'b0;
    branch_dest  = 32'h0;
  endtask

  task automatic expect_out(input string tag, input int wid, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(sched_valid), 32'd1);
    chk({tag, "_wid"}, 32'(sched_wid), 32'(wid));
    chk({tag, "_pc"}, sched_pc, pc);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_valid"}, 32'(sched_valid), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    clear_inputs();
    sched_ready = 1'b1;
    model_reset();

    // Reset values and the startup fetch stream
    do_reset();
    chk("rst_valid", 32'(sched_valid), 32'd0);
    chk("rst_wid", 32'(sched_wid), 32'd0);
    chk("rst_pc", sched_pc, 32'h0);
    step(); expect_out("boot0", 0, 32'h8000_0000);
    step(); expect_out("boot1", 0, 32'h8000_0004);
    step(); expect_out("boot2", 0, 32'h8000_0008);
    step(); expect_out("boot3", 0, 32'h8000_000C);

    // Spawn warps 1..3 while the current request is held; round-robin order
    sched_ready = 1'b0;
    wspawn_valid = 1'b1; wspawn_mask = 4'b1110; wspawn_pc = 32'h1000;
    step(); expect_out("spawn_hold", 0, 32'h8000_000C);
    clear_inputs();
    sched_ready = 1'b1;
    step(); expect_out("rr0", 1, 32'h1000);
    step(); expect_out("rr1", 2, 32'h1000);
    step(); expect_out("rr2", 3, 32'h1000);
    step(); expect_out("rr3", 0, 32'h8000_0010);
    step(); expect_out("rr4", 1, 32'h1004);

    // Stall the only warp, resolve not-taken, then taken
    do_reset();
    step(); expect_out("st_a", 0, 32'h8000_0000);
    step(); expect_out("st_b", 0, 32'h8000_0004);
    stall_valid = 1'b1; stall_wid = 2'd0;
    step(); expect_out("st_c", 0, 32'h8000_0008);
    clear_inputs();
    step(); expect_idle("st_idle0");
    step(); expect_idle("st_idle1");
    branch_valid = 1'b1; branch_wid = 2'd0; branch_taken = 1'b0;
    step(); expect_idle("nt_res");
    clear_inputs();
    step(); expect_out("nt_fall", 0, 32'h8000_000C);
    stall_valid = 1'b1; stall_wid = 2'd0;
    step(); expect_out("st_d", 0, 32'h8000_0010);
    clear_inputs();
    step(); expect_idle("st_idle2");
    branch_valid = 1'b1; branch_wid = 2'd0; branch_taken = 1'b1; branch_dest = 32'h2000;
    step(); expect_idle("tk_res");
    clear_inputs();
    step(); expect_out("tk_redir", 0, 32'h2000);

    // Hold warp 1 with ready low, then kill it with a taken branch
    do_reset();
    wspawn_valid = 1'b1; wspawn_mask = 4'b0011; wspawn_pc = 32'h1000;
    step(); expect_idle("h_spawn");
    clear_inputs();
    step(); expect_out("h_a", 1, 32'h1000);
    step(); expect_out("h_b", 0, 32'h1000);
    step(); expect_out("h_c", 1, 32'h1004);
    step(); expect_out("h_d", 0, 32'h1004);
    step(); expect_out("h_e", 1, 32'h1008);
    sched_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); expect_out("hold", 1, 32'h1008);
    end
    branch_valid = 1'b1; branch_wid = 2'd1; branch_taken = 1'b1; branch_dest = 32'h3000;
    step(); expect_idle("kill");
    clear_inputs();
    sched_ready = 1'b1;
    step(); expect_out("k_a", 0, 32'h1008);
    step(); expect_out("k_b", 1, 32'h3000);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      sched_ready  = ($urandom_range(3) != 0);
      wspawn_valid = ($urandom_range(24) == 0);
      wspawn_mask  = 4'($urandom);
      wspawn_pc    = $urandom;
      stall_valid  = ($urandom_range(4) == 0);
      stall_wid    = 2'($urandom);
      branch_valid = ($urandom_range(3) == 0);
      branch_wid   = 2'($urandom);
      branch_taken = 1'($urandom);
      branch_dest  = $urandom;
      reset        = ($urandom_range(400) == 0);
      step();
    end
    reset = 1'b0;
    clear_inputs();

    // Reset while a request is held
    sched_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    chk("mid_rst_valid", 32'(sched_valid), 32'd0);
    chk("mid_rst_wid", 32'(sched_wid), 32'd0);
    chk("mid_rst_pc", sched_pc, 32'h0);
    reset = 1'b0;
    sched_ready = 1'b1;
    step(); expect_out("mid_rst_boot", 0, 32'h8000_0000);

`ifdef BRANCH_PERF_EN
    // Branch outcome counters
    do_reset();
    for (int i = 0; i < 8; i++) begin
      branch_valid = 1'b1; branch_wid = 2'd2; branch_taken = (i < 5);
      branch_dest = $urandom;
      step();
    end
    clear_inputs();
    step();
    chk("perf_taken_5", perf_taken_o, 32'd5);
    chk("perf_not_taken_3", perf_not_taken_o, 32'd3);
    reset = 1'b1;
    step();
    chk("perf_taken_rst", perf_taken_o, 32'd0);
    chk("perf_not_taken_rst", perf_not_taken_o, 32'd0);
    reset = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
